// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: default FIFO geometry, MMIO offsets and
// status-register bit positions used by the CPU-side read path.
package uart_rx_fifo_pkg;

   localparam int FIFO_DEPTH  = 16;
   localparam int FIFO_ADDR_W = 4;

   localparam logic [31:0] UART_DATA_OFFSET   = 32'h0000_0000;
   localparam logic [31:0] UART_STATUS_OFFSET = 32'h0000_0004;

   localparam int STAT_NOT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT      = 1;
   localparam int STAT_OVERFLOW_BIT  = 2;

   typedef struct packed {
      logic overflow;
      logic full;
      logic not_empty;
   } uart_status_t;

   function automatic logic [31:0] pack_status(input uart_status_t st);
      logic [31:0] word;
      word                     = '0;
      word[STAT_NOT_EMPTY_BIT] = st.not_empty;
      word[STAT_FULL_BIT]      = st.full;
      word[STAT_OVERFLOW_BIT]  = st.overflow;
      return word;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port, one
// asynchronous read port. No reset; validity is owned by the pointers.
module uart_fifo_ram
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              i_Clock,
   input  logic              i_Wr_En,
   input  logic [ADDR_W-1:0] i_Wr_Addr,
   input  logic [7:0]        i_Wr_Data,
   input  logic [ADDR_W-1:0] i_Rd_Addr,
   output logic [7:0]        o_Rd_Data
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge i_Clock) begin
      if (i_Wr_En) begin
         mem_q[i_Wr_Addr] <= i_Wr_Data;
      end
   end

   assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between the UART receiver and the CPU data register,
// with level/full status, sticky overflow and a level-threshold interrupt.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int ADDR_W    = FIFO_ADDR_W,
   parameter int IRQ_LEVEL = 1
) (
   input  logic            i_Clock,
   input  logic            i_Reset,
   input  logic            i_Rx_DV,
   input  logic [7:0]      i_Rx_Byte,
   input  logic            i_Rd_En,
   input  logic            i_Clr_Overflow,
   output logic [7:0]      o_Rd_Data,
   output logic            o_Empty,
   output logic            o_Full,
   output logic [ADDR_W:0] o_Count,
   output logic            o_Overflow,
   output logic            o_Irq
);

   localparam int          CNT_W       = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] IRQ_C   = IRQ_LEVEL[ADDR_W:0];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              overflow_q, overflow_d;

   logic       empty_w;
   logic       full_w;
   logic       push_ok;
   logic       pop_ok;
   logic       drop_w;
   logic [7:0] ram_rd_data;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == DEPTH_C);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   // when the CPU reads at the same time.
   assign pop_ok  = i_Rd_En & ~empty_w;
   assign push_ok = i_Rx_DV & (~full_w | pop_ok);
   assign drop_w  = i_Rx_DV & full_w & ~pop_ok;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A new drop wins over a clear in the same cycle.
      if (drop_w) begin
         overflow_d = 1'b1;
      end else if (i_Clr_Overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   uart_fifo_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_Clock   (i_Clock),
      .i_Wr_En   (push_ok & ~i_Reset),
      .i_Wr_Addr (wr_ptr_q),
      .i_Wr_Data (i_Rx_Byte),
      .i_Rd_Addr (rd_ptr_q),
      .o_Rd_Data (ram_rd_data)
   );

   assign o_Rd_Data  = empty_w ? 8'h00 : ram_rd_data;
   assign o_Empty    = empty_w;
   assign o_Full     = full_w;
   assign o_Count    = count_q;
   assign o_Overflow = overflow_q;
   assign o_Irq      = (count_q >= IRQ_C) | overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_uart_rx_fifo;

   logic       i_Clock = 1'b0;
   logic       i_Reset;
   logic       i_Rx_DV;
   logic [7:0] i_Rx_Byte;
   logic       i_Rd_En;
   logic       i_Clr_Overflow;
   logic [7:0] o_Rd_Data;
   logic       o_Empty;
   logic       o_Full;
   logic [4:0] o_Count;
   logic       o_Overflow;
   logic       o_Irq;

   int errors = 0;
   int checks = 0;

   uart_rx_fifo #(
      .DEPTH     (16),
      .ADDR_W    (4),
      .IRQ_LEVEL (1)
   ) dut (
      .i_Clock        (i_Clock),
      .i_Reset        (i_Reset),
      .i_Rx_DV        (i_Rx_DV),
      .i_Rx_Byte      (i_Rx_Byte),
      .i_Rd_En        (i_Rd_En),
      .i_Clr_Overflow (i_Clr_Overflow),
      .o_Rd_Data      (o_Rd_Data),
      .o_Empty        (o_Empty),
      .o_Full         (o_Full),
      .o_Count        (o_Count),
      .o_Overflow     (o_Overflow),
      .o_Irq          (o_Irq)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cycle(input logic rst, input logic dv, input logic [7:0] b,
                        input logic rd, input logic clr);
      i_Reset        = rst;
      i_Rx_DV        = dv;
      i_Rx_Byte      = b;
      i_Rd_En        = rd;
      i_Clr_Overflow = clr;
      @(posedge i_Clock);
      #1;
      i_Reset        = 1'b0;
      i_Rx_DV        = 1'b0;
      i_Rx_Byte      = 8'h00;
      i_Rd_En        = 1'b0;
      i_Clr_Overflow = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      cycle(1'b0, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      i_Reset = 1'b1; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
      i_Rd_En = 1'b0; i_Clr_Overflow = 1'b0;
      #2;
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // Reset state
      check("rst_count", o_Count, 0);
      check("rst_empty", o_Empty, 1);
      check("rst_full", o_Full, 0);
      check("rst_ovf", o_Overflow, 0);
      check("rst_irq", o_Irq, 0);
      check("rst_data", o_Rd_Data, 8'h00);

      // Single byte push then pop
      push(8'hA5);
      check("a5_data", o_Rd_Data, 8'hA5);
      check("a5_empty", o_Empty, 0);
      check("a5_count", o_Count, 1);
      check("a5_irq", o_Irq, 1);
      pop();
      check("a5pop_empty", o_Empty, 1);
      check("a5pop_data", o_Rd_Data, 8'h00);
      check("a5pop_count", o_Count, 0);
      check("a5pop_irq", o_Irq, 0);

      // Fill 00..0F, then drain in order
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         if (i == 14) check("fill_notfull15", o_Full, 0);
      end
      check("fill_full", o_Full, 1);
      check("fill_count", o_Count, 16);
      check("fill_head", o_Rd_Data, 8'h00);
      for (int i = 0; i < 16; i++) begin
         check("fill_pop_data", o_Rd_Data, 8'(i));
         pop();
      end
      check("fill_drained_empty", o_Empty, 1);
      check("fill_drained_count", o_Count, 0);

      // Wrap-around: pointers sit at 1, so 10+10 pushes cross index 15
      for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
      for (int i = 0; i < 10; i++) begin
         check("wrap_pre_data", o_Rd_Data, 8'h40 + 8'(i));
         pop();
      end
      for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
      check("wrap_count", o_Count, 10);
      for (int i = 0; i < 10; i++) begin
         check("wrap_data", o_Rd_Data, 8'h20 + 8'(i));
         pop();
      end
      check("wrap_empty", o_Empty, 1);

      // Overflow, clear, then clear colliding with a new drop
      for (int i = 0; i < 16; i++) push(8'h50 + 8'(i));
      push(8'hFF);
      check("ovf_set", o_Overflow, 1);
      check("ovf_count", o_Count, 16);
      check("ovf_head", o_Rd_Data, 8'h50);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", o_Overflow, 0);
      check("ovf_clr_irq", o_Irq, 1);
      cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
      check("ovf_collide", o_Overflow, 1);
      check("ovf_collide_count", o_Count, 16);
      for (int i = 0; i < 16; i++) begin
         check("ovf_pop_data", o_Rd_Data, 8'h50 + 8'(i));
         pop();
      end
      check("ovf_drained_empty", o_Empty, 1);
      check("ovf_only_irq", o_Irq, 1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_final_clr", o_Overflow, 0);
      check("ovf_final_irq", o_Irq, 0);

      // Simultaneous push and pop while full
      for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
      cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
      check("sim_full_count", o_Count, 16);
      check("sim_full_ovf", o_Overflow, 0);
      check("sim_full_flag", o_Full, 1);
      for (int i = 1; i < 16; i++) begin
         check("sim_full_data", o_Rd_Data, 8'h60 + 8'(i));
         pop();
      end
      check("sim_full_last", o_Rd_Data, 8'hEE);
      pop();
      check("sim_full_empty", o_Empty, 1);

      // Simultaneous push and pop while empty
      cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      check("sim_empty_count", o_Count, 1);
      check("sim_empty_data", o_Rd_Data, 8'h77);
      pop();
      pop();
      check("underflow_count", o_Count, 0);
      check("underflow_empty", o_Empty, 1);
      check("underflow_data", o_Rd_Data, 8'h00);
      check("underflow_ovf", o_Overflow, 0);
      push(8'h88);
      check("underflow_next", o_Rd_Data, 8'h88);
      check("underflow_next_count", o_Count, 1);
      pop();

      // Reset mid-stream, with a push request in the reset cycle
      for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
      check("mid_pre_count", o_Count, 5);
      cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
      check("mid_rst_count", o_Count, 0);
      check("mid_rst_empty", o_Empty, 1);
      check("mid_rst_data", o_Rd_Data, 8'h00);
      push(8'h3C);
      check("mid_3c_data", o_Rd_Data, 8'h3C);
      check("mid_3c_count", o_Count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
